// File: rtl/complex_mag_stream_mul_arbiter.sv
// Round-robin sharing of one registered multiplier between NREQ requesters.
// The result is returned on a single ID-tagged channel with full backpressure.
module complex_mag_stream_mul_arbiter #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int DIN0_W = 39,
  parameter int DIN1_W = 4,
  parameter int DOUT_W = 43,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIN0_W-1:0]   req_din0,
  input  logic [NREQ*DIN1_W-1:0]   req_din1,
  output logic                     mul_ce,
  output logic [DIN0_W-1:0]        mul_din0,
  output logic [DIN1_W-1:0]        mul_din1,
  input  logic [DOUT_W-1:0]        mul_dout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DOUT_W-1:0]        res_data,
  output logic [ID_W-1:0]          res_id,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         stat_issue_cnt,
  output logic [CNT_W-1:0]         stat_stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a raised valid holds its data.

  logic            vld_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            grant;
  int              scan_idx;

  // The single multiplier stage and the shadow registers advance together.
  assign mul_ce = !vld_q || res_ready;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = ID_W'(scan_idx);
      end
    end
  end

  // Reset also blocks grants so nothing is accepted into a discarded stage.
  assign grant = found && mul_ce && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (winner == ID_W'(i));
    end
  end

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (grant) begin
      mul_din0 = req_din0[int'(winner)*DIN0_W +: DIN0_W];
      mul_din1 = req_din1[int'(winner)*DIN1_W +: DIN1_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      rr_ptr <= ID_W'(NREQ - 1);
    end else if (mul_ce) begin
      vld_q <= grant;
      if (grant) begin
        id_q   <= winner;
        rr_ptr <= winner;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (stat_clr)   stat_issue_cnt <= '0;
      else if (grant) stat_issue_cnt <= stat_issue_cnt + 1'b1;
      if (stat_clr)                  stat_stall_cnt <= '0;
      else if (vld_q && !res_ready)  stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end

  assign res_valid = vld_q;
  assign res_id    = id_q;
  assign res_data  = mul_dout;

endmodule

// File: tb/tb_complex_mag_stream_mul_arbiter.sv
// Directed bench for the shared-multiplier arbiter; a behavioural multiplier
// register stands in for the real core and a monitor checks every result.
module tb_complex_mag_stream_mul_arbiter;
  localparam int NREQ = 4, ID_W = 2, DIN0_W = 39, DIN1_W = 4, DOUT_W = 43, CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DIN0_W-1:0] req_din0;
  logic [NREQ*DIN1_W-1:0] req_din1;
  logic                   mul_ce;
  logic [DIN0_W-1:0]      mul_din0;
  logic [DIN1_W-1:0]      mul_din1;
  logic [DOUT_W-1:0]      mul_dout;
  logic                   res_valid;
  logic                   res_ready;
  logic [DOUT_W-1:0]      res_data;
  logic [ID_W-1:0]        res_id;
  logic                   stat_clr;
  logic [CNT_W-1:0]       stat_issue_cnt;
  logic [CNT_W-1:0]       stat_stall_cnt;

  logic [ID_W+DOUT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  complex_mag_stream_mul_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W),
    .DOUT_W(DOUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .stat_clr(stat_clr), .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  // clock / reset-free multiplier model (one register stage, no reset)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mul_ce) mul_dout <= DOUT_W'(mul_din0) * DOUT_W'(mul_din1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DIN0_W-1:0] d0, input logic [DIN1_W-1:0] d1);
    req_din0[i*DIN0_W +: DIN0_W] = d0;
    req_din1[i*DIN1_W +: DIN1_W] = d1;
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [DOUT_W-1:0] data);
    exp_q.push_back({id, data});
  endtask

  // scoreboard monitor: results leave the DUT on edges where valid & ready
  always @(negedge clk) begin
    logic [ID_W+DOUT_W-1:0] e;
    if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got id %0d data %0d expected none", res_id, res_data);
      end else begin
        e = exp_q.pop_front();
        if ({res_id, res_data} !== e) begin
          errors++;
          $display("FAIL result: got id %0d data %0d expected id %0d data %0d",
                   res_id, res_data, e[ID_W+DOUT_W-1:DOUT_W], e[DOUT_W-1:0]);
        end
      end
    end
  end

  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; req_valid = '0; req_din0 = '0; req_din1 = '0;
    res_ready = 1'b1; stat_clr = 1'b0;
    #2;
    req_valid = 4'hF;
    #1;
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_mul_ce", 64'(mul_ce), 64'd1);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_issue_cnt", 64'(stat_issue_cnt), 64'd0);
    check("reset_stall_cnt", 64'(stat_stall_cnt), 64'd0);
    req_valid = '0;
    tick(); tick();
    reset = 1'b0;

    // single requester
    set_req(2, 39'd1000, 4'd7);
    req_valid = 4'b0100;
    #1;
    check("single_grant", 64'(req_ready), 64'b0100);
    push_exp(2'd2, 43'd7000);
    tick();
    req_valid = '0;
    check("single_valid", 64'(res_valid), 64'd1);
    check("single_data", 64'(res_data), 64'd7000);
    check("single_id", 64'(res_id), 64'd2);
    check("single_issue_cnt", 64'(stat_issue_cnt), 64'd1);
    tick();

    // full contention from reset
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, DIN0_W'(100 + i), DIN1_W'(i + 1));
    req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      #1;
      check("contention_grant", 64'(req_ready), 64'(4'b0001 << order[g]));
      push_exp(ID_W'(order[g]), DOUT_W'((100 + order[g]) * (order[g] + 1)));
      tick();
    end
    req_valid = '0;
    tick();

    // backpressure: accept from 3, stall three cycles, then no-bubble handoff to 2
    set_req(3, 39'd12345, 4'd3);
    set_req(2, 39'd50, 4'd9);
    req_valid = 4'b1000;
    #1;
    check("bp_first_grant", 64'(req_ready), 64'b1000);
    push_exp(2'd3, 43'd37035);
    tick();
    req_valid = 4'b0100;
    res_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("bp_mul_ce", 64'(mul_ce), 64'd0);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_hold_data", 64'(res_data), 64'd37035);
      check("bp_hold_id", 64'(res_id), 64'd3);
      tick();
      check("bp_stall_cnt", 64'(stat_stall_cnt), 64'(k));
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'b0100);
    push_exp(2'd2, 43'd450);
    tick();
    req_valid = '0;
    check("bp_next_valid", 64'(res_valid), 64'd1);
    tick();

    // maximum operands
    set_req(0, {DIN0_W{1'b1}}, 4'd15);
    req_valid = 4'b0001;
    push_exp(2'd0, 43'd8246337208305);
    tick();
    req_valid = '0;
    check("max_data", 64'(res_data), 64'd8246337208305);
    tick();

    // statistics clear coincident with a grant
    set_req(1, 39'd6, 4'd4);
    req_valid = 4'b0010;
    stat_clr = 1'b1;
    #1;
    check("clr_grant", 64'(req_ready), 64'b0010);
    push_exp(2'd1, 43'd24);
    tick();
    stat_clr = 1'b0;
    req_valid = '0;
    check("clr_issue_cnt", 64'(stat_issue_cnt), 64'd0);
    tick();
    check("clr_issue_after", 64'(stat_issue_cnt), 64'd0);

    // reset mid-stream discards the held result; requester 1 wins afterwards
    set_req(0, 39'd7, 4'd7);
    set_req(1, 39'd21, 4'd2);
    set_req(3, 39'd99, 4'd5);
    req_valid = 4'b0001;
    res_ready = 1'b0;
    #1;
    check("rst_mid_grant0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'b1010;
    check("rst_mid_held", 64'(res_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid_drop", 64'(res_valid), 64'd0);
    check("rst_mid_no_grant", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    res_ready = 1'b1;
    #1;
    check("rst_mid_first", 64'(req_ready), 64'b0010);
    push_exp(2'd1, 43'd42);
    tick();
    req_valid = 4'b1000;
    #1;
    check("rst_mid_second", 64'(req_ready), 64'b1000);
    push_exp(2'd3, 43'd495);
    tick();
    req_valid = '0;

    begin
      int budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        tick();
        budget--;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/complex_mag_stream_mul_arbiter.md
# complex_mag_stream_mul_arbiter

Round-robin arbiter and sequencer that shares one `complex_mag_stream_mul_39ns_4ns_43_2_1` multiplier instance between `NREQ` requesters in the complex-magnitude stream datapath. It selects one operand pair per cycle and drives the multiplier's `ce`, `din0` and `din1`. It tracks the valid bit and requester ID alongside the multiplier's single output register. Results are returned on one valid/ready result channel tagged with the requester ID, with full backpressure. Issue and stall statistics counters are included.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester ID width; must equal clog2(`NREQ`).
- `DIN0_W`, 39: operand 0 width, unsigned.
- `DIN1_W`, 4: operand 1 width, unsigned.
- `DOUT_W`, 43: product width; must equal `DIN0_W`+`DIN1_W`.
- `CNT_W`, 32: statistics counter width.
- `clk`  in  1: single clock; everything is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  `NREQ`: request valid, one bit per requester.
- `req_ready`  out  `NREQ`: grant; at most one bit is high (one-hot or zero).
- `req_din0`  in  `NREQ`*`DIN0_W`: packed operand 0; requester i occupies bits [i*`DIN0_W` +: `DIN0_W`].
- `req_din1`  in  `NREQ`*`DIN1_W`: packed operand 1, packed the same way.
- `mul_ce`  out  1: clock enable to the multiplier.
- `mul_din0`  out  `DIN0_W`: operand 0 to the multiplier.
- `mul_din1`  out  `DIN1_W`: operand 1 to the multiplier.
- `mul_dout`  in  `DOUT_W`: multiplier registered output (its `buff0`).
- `res_valid`  out  1: result valid.
- `res_ready`  in  1: result consumer ready.
- `res_data`  out  `DOUT_W`: product; wired directly from `mul_dout`.
- `res_id`  out  `ID_W`: index of the requester that owns `res_data`.
- `stat_clr`  in  1: synchronous clear of both statistics counters.
- `stat_issue_cnt`  out  `CNT_W`: number of accepted requests.
- `stat_stall_cnt`  out  `CNT_W`: number of cycles with `res_valid` high and `res_ready` low.

## Operation
- State registers:
  - `vld_q`: shadow valid bit for the multiplier's output register.
  - `id_q`: shadow requester ID for the same register.
  - `rr_ptr` (`ID_W` bits): the last granted requester.
  - The two statistics counters.
- Advance condition: `mul_ce` = !`vld_q` | `res_ready`. The multiplier's single register stage and the shadow registers advance together, only when `mul_ce` is high.
- Arbitration (combinational):
  - The winner is the first requester with `req_valid` high, scanning from (`rr_ptr`+1) mod `NREQ` upward with wrap-around.
  - `req_ready`[winner] = `mul_ce`; all other `req_ready` bits are 0.
  - If no requester is valid, `req_ready` = 0.
- Operand mux: `mul_din0`/`mul_din1` carry the winner's operands when a grant is issued, and all-zero otherwise.
- On a clock edge with `mul_ce` high:
  - `vld_q` <= grant issued.
  - `id_q` <= winner, when a grant is issued; otherwise it holds.
  - `rr_ptr` <= winner, only when a grant is issued.
- On a clock edge with `mul_ce` low, all state holds. Pending requests wait; `req_ready` stays 0.
- Result channel: `res_valid` = `vld_q`, `res_id` = `id_q`, `res_data` = `mul_dout`. The result is held stable while `res_valid` is high and `res_ready` is low.
- Arithmetic: unsigned product, zero-extended operands, no truncation. Maximum value is (2^39-1)*15 = 8246337208305.
- Counters:
  - `stat_issue_cnt` increments on every grant.
  - `stat_stall_cnt` increments on every cycle with `res_valid` high and `res_ready` low.
  - Both wrap modulo 2^`CNT_W`.
  - `stat_clr` has priority over increment.
- Reset values: `vld_q`=0, `id_q`=0, `rr_ptr`=`NREQ`-1 (so requester 0 wins first), counters 0.
- Reset effects on outputs:
  - `res_valid`=0 immediately; `mul_ce` becomes 1.
  - The multiplier register is not reset; its content is masked by `vld_q`.
  - Asserting `reset` mid-operation discards any in-flight result. No grant is issued while `reset` is high (`req_ready`=0).

## Timing
- Latency: a request accepted at edge T (`req_valid`&`req_ready`) appears as `res_valid`/`res_data` immediately after edge T.
- Throughput: one result per cycle while `res_ready` stays high.
- Combinational paths:
  - `res_ready` -> `mul_ce` -> `req_ready`.
  - `req_valid` -> `req_ready`, `mul_din0`/`mul_din1`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Simultaneous events: consuming a result and accepting a new request in the same cycle is allowed, with no bubble.
- Requester rules: once raised, a requester holds `req_valid` and its operands until granted. Dropping `req_valid` without a grant is allowed and simply removes that requester from arbitration.

## Test plan
- Single requester:
  - Stimulus: requester 2 issues din0=1000, din1=7 with `res_ready`=1.
  - Required: `req_ready`[2] high in the same cycle; next cycle `res_valid`=1, `res_data`=7000, `res_id`=2; `stat_issue_cnt`=1.
- Full contention:
  - Stimulus: all 4 requesters held valid, `res_ready`=1, starting from reset.
  - Required: grant order 0,1,2,3,0,1; one result per cycle; `res_id` follows the same sequence.
- Backpressure:
  - Stimulus: issue a request, then hold `res_ready`=0 for 3 cycles.
  - Required: `res_valid`=1 with `res_data`/`res_id` stable; `mul_ce`=0; `req_ready`=0; `stat_stall_cnt`=3; on release the next grant follows with no bubble.
- Maximum operands:
  - Stimulus: din0=2^39-1, din1=15.
  - Required: `res_data`=8246337208305.
- Reset mid-stream:
  - Stimulus: assert `reset` while `res_valid`=1 and requesters 1 and 3 are pending.
  - Required: `res_valid` drops asynchronously; after release the first grant goes to requester 1.
- Statistics clear:
  - Stimulus: pulse `stat_clr` in the same cycle as a grant.
  - Required: `stat_issue_cnt`=0 on the next cycle.
